// File: rtl/judge_pkg.sv
// Shared types and constants for the note judge: FSM states, per-lane points and lane indices.
package judge_pkg;

  typedef enum logic [1:0] {LOAD, WAIT, OPEN, DONE} judge_state_e;

  localparam int unsigned PTS_PERFECT = 3;
  localparam int unsigned PTS_GOOD    = 1;

  localparam int unsigned RED    = 0;
  localparam int unsigned GREEN  = 1;
  localparam int unsigned BLUE   = 2;
  localparam int unsigned YELLOW = 3;

  function automatic logic [2:0] popcount4(input logic [3:0] v);
    return 3'(v[RED]) + 3'(v[GREEN]) + 3'(v[BLUE]) + 3'(v[YELLOW]);
  endfunction

endpackage

// File: rtl/note_judge_if.sv
// Row/key inputs and judge results exchanged between the top and one note_judge instance.
interface note_judge_if #(
  parameter int unsigned Y_W     = 10,
  parameter int unsigned SCORE_W = 16,
  parameter int unsigned COMBO_W = 8
);
  logic [Y_W-1:0]     y_pos;
  logic [3:0]         command_in;
  logic [3:0]         keys;
  logic [SCORE_W-1:0] score;
  logic [COMBO_W-1:0] combo;
  logic               hit_pulse;
  logic               perfect_pulse;
  logic               miss_pulse;
  logic [3:0]         pending;

  modport master (
    output y_pos, command_in, keys,
    input  score, combo, hit_pulse, perfect_pulse, miss_pulse, pending
  );

  modport slave (
    input  y_pos, command_in, keys,
    output score, combo, hit_pulse, perfect_pulse, miss_pulse, pending
  );
endinterface

// File: rtl/key_edge.sv
// Per-lane 2-FF synchronizer followed by a registered rising-edge detector (one-cycle press).
module key_edge #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [WIDTH-1:0] i_keys,
  output logic [WIDTH-1:0] o_press
);
  logic [WIDTH-1:0] r_sync1, r_sync2, r_last, r_press;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_last  <= '0;
      r_press <= '0;
    end else begin
      r_sync1 <= i_keys;
      r_sync2 <= r_sync1;
      r_last  <= r_sync2;
      r_press <= r_sync2 & ~r_last;
    end
  end

  assign o_press = r_press;
endmodule

// File: rtl/note_judge.sv
// Judges one scrolling pattern row against the player's keys; tracks score, combo and pulses.
// Optional NOTE_JUDGE_GHOST_PENALTY_EN: each wrong-press lane costs one point (floor 0).
module note_judge
  import judge_pkg::*;
#(
  parameter int unsigned Y_W         = 10,
  parameter int unsigned HIT_Y       = 440,
  parameter int unsigned GOOD_WIN    = 16,
  parameter int unsigned PERFECT_WIN = 4,
  parameter int unsigned SCORE_W     = 16,
  parameter int unsigned COMBO_W     = 8
) (
  input logic        CLOCK_25,
  input logic        reset,
  note_judge_if.slave bus
);
  localparam logic [Y_W:0]       HitY     = (Y_W+1)'(HIT_Y);
  localparam logic [Y_W:0]       WinLo    = (Y_W+1)'(HIT_Y - GOOD_WIN);
  localparam logic [Y_W:0]       WinHi    = (Y_W+1)'(HIT_Y + GOOD_WIN);
  localparam logic [Y_W:0]       PerfWin  = (Y_W+1)'(PERFECT_WIN);
  localparam logic [SCORE_W+3:0] ScoreMax = (SCORE_W+4)'({SCORE_W{1'b1}});
  localparam logic [COMBO_W+2:0] ComboMax = (COMBO_W+3)'({COMBO_W{1'b1}});

  judge_state_e       r_state, w_state_next;
  logic [Y_W-1:0]     r_prev_y;
  logic [3:0]         r_pending, w_pending_next;
  logic [SCORE_W-1:0] r_score, w_score_add, w_score_next;
  logic [COMBO_W-1:0] r_combo, w_combo_next;
  logic               r_hit, r_perfect, r_miss;

  logic [3:0]         w_press, w_hit_lanes, w_wrong_lanes;
  logic               w_miss, w_wrap, w_in_win, w_past_win, w_perfect;
  logic [Y_W:0]       w_y_ext, w_dist;
  logic [2:0]         w_n_hits;
  logic [3:0]         w_pts;
  logic [SCORE_W+3:0] w_score_sum;
  logic [COMBO_W+2:0] w_combo_sum;

  key_edge #(.WIDTH(4)) u_key_edge (
    .i_clk   (CLOCK_25),
    .i_reset (reset),
    .i_keys  (bus.keys),
    .o_press (w_press)
  );

  assign w_y_ext    = {1'b0, bus.y_pos};
  assign w_wrap     = bus.y_pos < r_prev_y;
  assign w_in_win   = (w_y_ext >= WinLo) && (w_y_ext <= WinHi);
  assign w_past_win = w_y_ext > WinHi;
  assign w_dist     = (w_y_ext >= HitY) ? (w_y_ext - HitY) : (HitY - w_y_ext);
  assign w_perfect  = w_dist <= PerfWin;

  // State register
  always_ff @(posedge CLOCK_25) begin
    if (reset) begin
      r_state  <= LOAD;
      r_prev_y <= '0;
    end else begin
      r_state  <= w_state_next;
      r_prev_y <= bus.y_pos;
    end
  end

  // Next-state logic; a wrap always restarts the row.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      LOAD:       w_state_next = (bus.command_in == 4'b0) ? DONE : WAIT;
      WAIT, OPEN: begin
        if (w_pending_next == 4'b0) w_state_next = DONE;
        else if (w_in_win)          w_state_next = OPEN;
        else                        w_state_next = WAIT;
      end
      default:    w_state_next = r_state;
    endcase
    if (w_wrap) w_state_next = LOAD;
  end

  // Judgement: any press that does not clear a pending in-window lane is a wrong press.
  always_comb begin
    w_hit_lanes    = 4'b0;
    w_wrong_lanes  = w_press;
    w_miss         = 1'b0;
    w_pending_next = r_pending;
    case (r_state)
      LOAD:       w_pending_next = bus.command_in;
      WAIT, OPEN: begin
        if (w_in_win) begin
          w_hit_lanes    = w_press & r_pending;
          w_wrong_lanes  = w_press & ~r_pending;
          w_pending_next = r_pending & ~w_press;
        end else if (w_past_win && (r_pending != 4'b0)) begin
          w_miss         = 1'b1;
          w_pending_next = 4'b0;
        end
      end
      default:    w_pending_next = r_pending;
    endcase
  end

  // Scoring with saturation; the penalty (when enabled) lands after the hit addition.
  always_comb begin
    w_n_hits    = popcount4(w_hit_lanes);
    w_pts       = w_perfect ? 4'(PTS_PERFECT * w_n_hits) : 4'(PTS_GOOD * w_n_hits);
    w_score_sum = (SCORE_W+4)'(r_score) + (SCORE_W+4)'(w_pts);
    w_score_add = (w_score_sum > ScoreMax) ? r_score | {SCORE_W{1'b1}}
                                           : w_score_sum[SCORE_W-1:0];
`ifdef NOTE_JUDGE_GHOST_PENALTY_EN
    w_score_next = (w_score_add > SCORE_W'(popcount4(w_wrong_lanes)))
                   ? w_score_add - SCORE_W'(popcount4(w_wrong_lanes)) : '0;
`else
    w_score_next = w_score_add;
`endif
    w_combo_sum  = (COMBO_W+3)'(r_combo) + (COMBO_W+3)'(w_n_hits);
    w_combo_next = (w_combo_sum > ComboMax) ? {COMBO_W{1'b1}} : w_combo_sum[COMBO_W-1:0];
    if (w_miss || (w_wrong_lanes != 4'b0)) w_combo_next = '0;
  end

  always_ff @(posedge CLOCK_25) begin
    if (reset) begin
      r_pending <= 4'b0;
      r_score   <= '0;
      r_combo   <= '0;
      r_hit     <= 1'b0;
      r_perfect <= 1'b0;
      r_miss    <= 1'b0;
    end else begin
      r_pending <= w_pending_next;
      r_score   <= w_score_next;
      r_combo   <= w_combo_next;
      r_hit     <= w_hit_lanes != 4'b0;
      r_perfect <= (w_hit_lanes != 4'b0) && w_perfect;
      r_miss    <= w_miss;
    end
  end

  assign bus.score         = r_score;
  assign bus.combo         = r_combo;
  assign bus.hit_pulse     = r_hit;
  assign bus.perfect_pulse = r_perfect;
  assign bus.miss_pulse    = r_miss;
  assign bus.pending       = r_pending;
endmodule

// File: tb/tb_note_judge.sv
// Scoreboard bench for note_judge: directed rows push expected pulse events, a monitor checks them.
module tb_note_judge;
  localparam int unsigned SW = 4;

  typedef struct packed {
    logic          hit;
    logic          perf;
    logic          miss;
    logic [SW-1:0] score;
    logic [7:0]    combo;
    logic [3:0]    pend;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   y_cur = 0;
  exp_t  exp_q[$];
  string name_q[$];

  always #20 clk = ~clk;

  note_judge_if #(.Y_W(10), .SCORE_W(SW), .COMBO_W(8)) bus ();

  note_judge #(
    .Y_W(10), .HIT_Y(440), .GOOD_WIN(16), .PERFECT_WIN(4), .SCORE_W(SW), .COMBO_W(8)
  ) dut (
    .CLOCK_25 (clk),
    .reset    (rst),
    .bus      (bus)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  task automatic push(input string nm, input logic h, input logic p, input logic m,
                      input int sc, input int cb, input logic [3:0] pd);
    exp_t e;
    e.hit = h; e.perf = p; e.miss = m;
    e.score = SW'(sc); e.combo = 8'(cb); e.pend = pd;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // Monitor: every pulse must match the oldest expected event.
  always begin
    exp_t  e;
    string nm;
    @(posedge clk);
    #1;
    if (bus.hit_pulse || bus.miss_pulse) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_pulse actual hit=%0b miss=%0b required no pulse",
                 bus.hit_pulse, bus.miss_pulse);
      end else begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        chk({nm, "_hit"},     32'(bus.hit_pulse),     32'(e.hit));
        chk({nm, "_perfect"}, 32'(bus.perfect_pulse), 32'(e.perf));
        chk({nm, "_miss"},    32'(bus.miss_pulse),    32'(e.miss));
        chk({nm, "_score"},   32'(bus.score),         32'(e.score));
        chk({nm, "_combo"},   32'(bus.combo),         32'(e.combo));
        chk({nm, "_pending"}, 32'(bus.pending),       32'(e.pend));
      end
    end
  end

  task automatic drain(input string nm);
    for (int c = 0; c < 20 && exp_q.size() != 0; c++) @(negedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout actual=%0d events outstanding required=0", nm, exp_q.size());
      exp_q.delete();
      name_q.delete();
    end
  endtask

  task automatic step_to(input int target);
    for (int v = y_cur + 1; v <= target; v++) begin
      @(negedge clk);
      bus.y_pos = 10'(v);
    end
    y_cur = target;
  endtask

  task automatic do_reset(input logic [3:0] cmd);
    @(negedge clk);
    rst = 1'b1; bus.y_pos = '0; bus.command_in = cmd; bus.keys = '0; y_cur = 0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic wrap_row(input logic [3:0] cmd);
    @(negedge clk);
    bus.command_in = cmd; bus.y_pos = '0; y_cur = 0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic press(input logic [3:0] mask, input int hold, input bit chk_lat);
    @(negedge clk);
    bus.keys = mask;
    for (int c = 1; c <= hold; c++) begin
      @(negedge clk);
      if (chk_lat && c == 3) chk("latency_early", 32'(bus.hit_pulse), 32'd0);
      if (chk_lat && c == 4) chk("latency_hit",   32'(bus.hit_pulse), 32'd1);
    end
    bus.keys = '0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #10_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    bus.y_pos = '0; bus.command_in = '0; bus.keys = '0;

    // Reset values
    @(negedge clk);
    rst = 1'b1; bus.command_in = 4'b0101;
    @(negedge clk);
    chk("rst_score",   32'(bus.score),         32'd0);
    chk("rst_combo",   32'(bus.combo),         32'd0);
    chk("rst_pending", 32'(bus.pending),       32'd0);
    chk("rst_hit",     32'(bus.hit_pulse),     32'd0);
    chk("rst_perfect", 32'(bus.perfect_pulse), 32'd0);
    chk("rst_miss",    32'(bus.miss_pulse),    32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("t1_load", 32'(bus.pending), 32'b0101);

    // Two lanes perfect at the target line
    step_to(440);
    push("t1_dual", 1, 1, 0, 6, 2, 4'b0000);
    press(4'b0101, 6, 1'b1);
    drain("t1");

    // Good hit 10 px early
    do_reset(4'b0010);
    step_to(430);
    push("t2_good", 1, 0, 0, 1, 1, 4'b0000);
    press(4'b0010, 6, 1'b0);
    drain("t2");

    // Miss: still pending on the last window line, miss one line later
    wrap_row(4'b1000);
    chk("t3_load", 32'(bus.pending), 32'b1000);
    step_to(456);
    @(negedge clk);
    chk("t3_edge_pending", 32'(bus.pending), 32'b1000);
    push("t3_miss", 0, 0, 1, 1, 0, 4'b0000);
    step_to(457);
    drain("t3");

    // Perfect boundary (dist 4), good boundary (dist 5), then a wrong press in DONE
    do_reset(4'b1111);
    step_to(436);
    push("t4_quad", 1, 1, 0, 12, 4, 4'b0000);
    press(4'b1111, 6, 1'b0);
    drain("t4a");
    wrap_row(4'b0001);
    step_to(445);
    push("t4_good", 1, 0, 0, 13, 5, 4'b0000);
    press(4'b0001, 6, 1'b0);
    drain("t4b");
    press(4'b1000, 6, 1'b0);
    chk("t4_wrong_combo", 32'(bus.combo), 32'd0);
`ifdef NOTE_JUDGE_GHOST_PENALTY_EN
    chk("t4_wrong_score", 32'(bus.score), 32'd12);
`else
    chk("t4_wrong_score", 32'(bus.score), 32'd13);
`endif

    // Held key gives one hit; score saturates at 15
    wrap_row(4'b0001);
    step_to(440);
    push("t5_hold", 1, 1, 0, 15, 1, 4'b0000);
    press(4'b0001, 100, 1'b0);
    drain("t5");
    chk("t5_hold_combo", 32'(bus.combo), 32'd1);
    step_to(480);
    wrap_row(4'b0100);
    chk("t5_reload", 32'(bus.pending), 32'b0100);
    step_to(440);
    push("t5_sat", 1, 1, 0, 15, 2, 4'b0000);
    press(4'b0100, 6, 1'b0);
    drain("t5s");

    // Reset while OPEN clears everything on the next cycle
    wrap_row(4'b0011);
    step_to(430);
    @(negedge clk);
    chk("t6_open_pending", 32'(bus.pending), 32'b0011);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_score",   32'(bus.score),      32'd0);
    chk("t6_combo",   32'(bus.combo),      32'd0);
    chk("t6_pending", 32'(bus.pending),    32'd0);
    chk("t6_hit",     32'(bus.hit_pulse),  32'd0);
    chk("t6_miss",    32'(bus.miss_pulse), 32'd0);
    rst = 1'b0;

    // Empty row goes straight to DONE; a wrong press at score 0 keeps it at 0
    do_reset(4'b0000);
    press(4'b0010, 6, 1'b0);
    chk("t7_floor_score", 32'(bus.score),   32'd0);
    chk("t7_floor_combo", 32'(bus.combo),   32'd0);
    chk("t7_pending",     32'(bus.pending), 32'd0);

    repeat (5) @(negedge clk);
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/note_judge.md
Name: note_judge

Overview:
- Consumer side of the scrolling-note interface: watches one pattern row's y_pos and 4-lane command, reads the player's 4 lane keys, and judges each note as PERFECT, GOOD or MISS.
- Accumulates score and combo, and emits one-cycle hit/miss pulses to the top (HUD, sound).
- Sits beside the pattern row in the top. One instance per row; the top sums scores.

Parameters:
- Y_W, 10, width of y_pos (matches VGA line range 0..480)
- HIT_Y, 440, target line centre in pixels
- GOOD_WIN, 16, half-width of the judged window (pixels)
- PERFECT_WIN, 4, half-width of the perfect window (pixels, < GOOD_WIN)
- SCORE_W, 16, score register width
- COMBO_W, 8, combo register width

Ports:
- CLOCK_25  in  1  system clock
- reset  in  1  synchronous, active-high
- y_pos  in  Y_W  current row centre from the pattern row; wraps 480->0
- command_in  in  4  lane mask of the row (bit0 red .. bit3 yellow)
- keys  in  4  raw player keys, 1 = pressed, asynchronous
- score  out  SCORE_W  accumulated points
- combo  out  COMBO_W  consecutive judged notes without miss/wrong press
- hit_pulse  out  1  one cycle per judged hit event
- perfect_pulse  out  1  one cycle, with hit_pulse when any lane in the event was perfect
- miss_pulse  out  1  one cycle when the row leaves the window with notes pending
- pending  out  4  lanes of the current row still unjudged

Behaviour:
- Reset: score=0, combo=0, all pulses=0, pending=0, prev_y=0, state=LOAD. Reset mid-row discards the row.
- Key path:
  - Each key goes through a 2-FF synchronizer, then rising-edge detection.
  - press[i] is asserted for exactly one cycle.
  - Fixed latency: 3 cycles from the first clock edge sampling the key high to hit_pulse.
  - Holding a key yields a single press.
- Row tracking:
  - prev_y is registered every cycle.
  - Wrap is detected when y_pos < prev_y, and forces state LOAD, overriding all other transitions in that cycle.
- States:
  - LOAD (1 cycle): pending <= command_in. Go to WAIT; go directly to DONE if command_in == 0.
  - WAIT: y_pos < HIT_Y-GOOD_WIN. Presses here count as wrong presses.
  - OPEN: HIT_Y-GOOD_WIN <= y_pos <= HIT_Y+GOOD_WIN.
    - press[i] with pending[i] clears pending[i] (a hit).
    - press[i] without pending[i] is a wrong press.
    - pending becomes 0 -> DONE.
  - y_pos > HIT_Y+GOOD_WIN while pending != 0 -> miss_pulse for 1 cycle, combo <= 0, pending <= 0, DONE.
  - DONE: any press is a wrong press. Wait for wrap.
- Scoring, applied in the same cycle as a hit:
  - dist = |y_pos - HIT_Y|, computed on Y_W+1 bits (no underflow).
  - Each hit lane adds 3 points if dist <= PERFECT_WIN, else 1.
  - Several lanes in one cycle sum their points; hit_pulse is asserted once.
  - combo increments by the number of lanes hit that cycle.
- Saturation: score saturates at 2^SCORE_W-1; combo saturates at 2^COMBO_W-1. Neither wraps.
- Wrong press: combo <= 0; score unchanged. Hit and wrong press in the same cycle: apply the hit points, then combo <= 0.
- Simultaneous exit of window and hit in the same cycle: the hit on the last in-window y value is counted first; the miss is judged only on the remaining pending lanes.

Optional Feature:
- Macro: NOTE_JUDGE_GHOST_PENALTY_EN.
  - Defined: each wrong-press lane subtracts 1 from score, floor at 0, applied after any hit addition that cycle.
  - Undefined: wrong presses only clear combo.

Decomposition:
- Package judge_pkg holds:
  - state enum (LOAD, WAIT, OPEN, DONE)
  - PTS_PERFECT=3, PTS_GOOD=1
  - lane index constants (RED=0, GREEN=1, BLUE=2, YELLOW=3)
- Sub-module key_edge: per-lane 2-FF synchronizer plus rising-edge detector, instantiated with width 4.

Test Plan:
- reset; command_in=4'b0101; y_pos stepped from 0 to 440; keys 0 and 2 rise together at y=440 -> one hit_pulse, perfect_pulse=1, score=6, combo=2, pending=0.
- command_in=4'b0010; key1 rises at y=430 -> score=1 (GOOD), perfect_pulse=0, combo=1.
- command_in=4'b1000; no key pressed; y_pos reaches 457 -> miss_pulse for 1 cycle, combo=0, score unchanged.
- combo=5 in DONE; key3 pressed -> combo=0, score unchanged. With NOTE_JUDGE_GHOST_PENALTY_EN: score decrements by 1 (0 stays 0).
- key0 held high for 100 cycles at y=440 -> exactly one hit; y_pos wraps 480->0 -> LOAD reloads pending from command_in.
- score preloaded near max via repeated hits with SCORE_W=4 -> score saturates at 15; reset asserted while in OPEN -> all outputs 0 on the next cycle.
